fetch_controller: RTL and testbench

Sequencer for the fetch stage: owns the program counter and drives the instruction-memory address. It runs the fetch state machine (IDLE/RUN/HALT) and applies stall and branch/jump redirect with a one-cycle flush bubble. It also arbitrates the instruction-memory debug write port, so program loading is only possible while the core is not fetching. It sits between the hazard/branch logic and the instruction memory and replaces free-running PC+4 logic.

---
 rtl/fetch_ctrl_pkg.sv | 16 +
 rtl/fetch_controller.sv | 105 ++++++++++
 tb/tb_fetch_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencer.
// State encoding, PC stride and alignment mask.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } fetch_state_e;

  localparam int unsigned PC_STEP = 4;

  // Low PC bits forced to zero on redirect.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: PC, IDLE/RUN/HALT FSM,
// redirect bubble and imem debug-port gating.
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt_req,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            dbg_wr_en,
  input  logic [XLEN-1:0] dbg_addr,
  input  logic [XLEN-1:0] dbg_instr,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_dbg_wr_en,
  output logic [XLEN-1:0] imem_dbg_addr,
  output logic [XLEN-1:0] imem_dbg_instr,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic [1:0]      state,
  output logic [XLEN-1:0] fetch_count,
  output logic            dbg_reject
);

  localparam logic [XLEN-1:0] STEP =
    XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] MASK =
    ~XLEN'(ALIGN_MASK);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            bubble_q, bubble_d;
  logic [XLEN-1:0] count_q;
  logic            reject_q;
  logic            running;
  logic            accept;

  assign running     = (state_q == RUN);
  assign fetch_valid = running & ~bubble_q
                     & ~halt_req;
  assign accept      = fetch_valid & ~stall;

  assign fetch_pc    = pc_q;
  assign imem_addr   = pc_q;
  assign pc_plus4    = pc_q + STEP;
  assign state       = state_q;
  assign fetch_count = count_q;
  assign dbg_reject  = reject_q;

  assign imem_dbg_wr_en = dbg_wr_en & ~running;
  assign imem_dbg_addr  = dbg_addr;
  assign imem_dbg_instr = dbg_instr;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    bubble_d = bubble_q;
    unique case (1'b1)
      (state_q == RUN): begin
        if (redirect_valid) begin
          pc_d     = redirect_target & MASK;
          bubble_d = 1'b1;
        end else if (halt_req) begin
          state_d  = HALT;
          bubble_d = 1'b0;
        end else if (stall) begin
          bubble_d = bubble_q;
        end else if (bubble_q) begin
          // Bubble slot: target PC becomes valid next.
          bubble_d = 1'b0;
        end else begin
          pc_d = pc_q + STEP;
        end
      end
      default: begin
        bubble_d = 1'b0;
        if (start) state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_VECTOR;
      bubble_q <= 1'b0;
      count_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      bubble_q <= bubble_d;
      if (accept) count_q <= count_q + 1'b1;
      if (running && dbg_wr_en)
        reject_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller.
// Hand-computed PC/count/state expectations.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, halt_req, stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        dbg_wr_en;
  logic [31:0] dbg_addr, dbg_instr;
  logic [31:0] imem_addr;
  logic        imem_dbg_wr_en;
  logic [31:0] imem_dbg_addr, imem_dbg_instr;
  logic [31:0] fetch_pc, pc_plus4;
  logic        fetch_valid;
  logic [1:0]  state;
  logic [31:0] fetch_count;
  logic        dbg_reject;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_controller #(
    .XLEN(32),
    .RESET_VECTOR(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .halt_req(halt_req),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .dbg_wr_en(dbg_wr_en),
    .dbg_addr(dbg_addr),
    .dbg_instr(dbg_instr),
    .imem_addr(imem_addr),
    .imem_dbg_wr_en(imem_dbg_wr_en),
    .imem_dbg_addr(imem_dbg_addr),
    .imem_dbg_instr(imem_dbg_instr),
    .fetch_pc(fetch_pc),
    .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid),
    .state(state),
    .fetch_count(fetch_count),
    .dbg_reject(dbg_reject)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;

  initial begin
    rst = 1'b1;
    start = 0; halt_req = 0; stall = 0;
    redirect_valid = 0; redirect_target = 0;
    dbg_wr_en = 0; dbg_addr = 0; dbg_instr = 0;
    #3;
    check("rst_pc", fetch_pc, 32'h0);
    check("rst_imem", imem_addr, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_valid", {31'b0, fetch_valid}, 0);
    check("rst_state", {30'b0, state}, 0);
    check("rst_cnt", fetch_count, 0);
    check("rst_rej", {31'b0, dbg_reject}, 0);
    step();
    rst = 1'b0;

    // Program load in IDLE
    for (int i = 0; i < 4; i++) begin
      dbg_wr_en = 1;
      dbg_addr  = i * 4;
      dbg_instr = 32'hA000_0000 + i;
      #1;
      check("ld_we", {31'b0, imem_dbg_wr_en}, 1);
      check("ld_addr", imem_dbg_addr, i * 4);
      check("ld_data", imem_dbg_instr,
            32'hA000_0000 + i);
      step();
    end
    dbg_wr_en = 0;
    check("idle_pc", fetch_pc, 32'h0);

    start = 1;
    step();
    start = 0;
    check("run_state", {30'b0, state}, S_RUN);
    for (int i = 0; i < 4; i++) begin
      check("seq_pc", fetch_pc, i * 4);
      check("seq_valid", {31'b0, fetch_valid}, 1);
      step();
    end
    check("seq_cnt", fetch_count, 4);
    check("seq_pc10", fetch_pc, 32'h10);

    // Stall hold, then redirect under stall
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stl_pc", fetch_pc, 32'h10);
      check("stl_cnt", fetch_count, 4);
    end
    redirect_valid = 1;
    redirect_target = 32'h43;
    step();
    redirect_valid = 0;
    stall = 0;
    check("rd_pc", fetch_pc, 32'h40);
    check("rd_bubble", {31'b0, fetch_valid}, 0);
    check("rd_cnt", fetch_count, 4);
    step();
    check("rd2_pc", fetch_pc, 32'h40);
    check("rd2_valid", {31'b0, fetch_valid}, 1);
    step();
    check("rd3_pc", fetch_pc, 32'h44);
    check("rd3_cnt", fetch_count, 5);

    // Redirect to 0x20 then halt
    redirect_valid = 1;
    redirect_target = 32'h20;
    step();
    redirect_valid = 0;
    check("h_cnt0", fetch_count, 6);
    step();
    check("h_pc", fetch_pc, 32'h20);
    check("h_valid", {31'b0, fetch_valid}, 1);
    halt_req = 1;
    #1;
    check("h_vkill", {31'b0, fetch_valid}, 0);
    step();
    check("h_state", {30'b0, state}, S_HALT);
    check("h_pc2", fetch_pc, 32'h20);
    check("h_cnt", fetch_count, 6);
    dbg_wr_en = 1;
    dbg_addr = 32'h100;
    dbg_instr = 32'hDEAD_BEEF;
    #1;
    check("h_dbg_we", {31'b0, imem_dbg_wr_en}, 1);
    check("h_dbg_d", imem_dbg_instr, 32'hDEAD_BEEF);
    step();
    halt_req = 0;
    dbg_wr_en = 0;
    check("h_stay", {30'b0, state}, S_HALT);
    check("h_norej", {31'b0, dbg_reject}, 0);
    start = 1;
    step();
    start = 0;
    check("res_state", {30'b0, state}, S_RUN);
    check("res_pc", fetch_pc, 32'h20);
    check("res_valid", {31'b0, fetch_valid}, 1);

    // Loader write during RUN is rejected
    dbg_wr_en = 1;
    #1;
    check("rj_we", {31'b0, imem_dbg_wr_en}, 0);
    step();
    dbg_wr_en = 0;
    check("rj_flag", {31'b0, dbg_reject}, 1);
    check("rj_pc", fetch_pc, 32'h24);
    step();
    check("rj_sticky", {31'b0, dbg_reject}, 1);
    check("rj_cnt", fetch_count, 8);

    // Wrap at top of address space
    redirect_valid = 1;
    redirect_target = 32'hFFFF_FFFF;
    step();
    redirect_valid = 0;
    check("wr_pc", fetch_pc, 32'hFFFF_FFFC);
    check("wr_cnt", fetch_count, 9);
    step();
    check("wr_pc4", pc_plus4, 32'h0);
    step();
    check("wr_pc0", fetch_pc, 32'h0);
    check("wr_cnt2", fetch_count, 10);

    // Asynchronous reset mid-RUN
    #2;
    redirect_valid = 1;
    redirect_target = 32'h80;
    rst = 1;
    #1;
    check("ar_state", {30'b0, state}, S_IDLE);
    check("ar_pc", fetch_pc, 32'h0);
    check("ar_cnt", fetch_count, 0);
    check("ar_rej", {31'b0, dbg_reject}, 0);
    step();
    rst = 0;
    redirect_valid = 0;
    step();
    check("ar_idle", {30'b0, state}, S_IDLE);
    check("ar_pc2", fetch_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
